// File: rtl/gold_scrambler_pkg.sv
// Gold-code symbol scrambler: shared widths, LFSR constants and types.
// Tap constants are bit masks over the 18-bit x/y registers.
package gold_scrambler_pkg;
  localparam int LFSR_W = 18;

  localparam logic [LFSR_W-1:0] X_RST = 18'h00001;
  localparam logic [LFSR_W-1:0] Y_RST = 18'h3FFFF;

  // feedback into bit 17: x7^x0, y10^y7^y5^y0
  localparam logic [LFSR_W-1:0] X_FB_TAPS = 18'h00081;
  localparam logic [LFSR_W-1:0] Y_FB_TAPS = 18'h004A1;

  // Rn[1]: x4,x6,x15 and y5,y6,y8..y15
  localparam logic [LFSR_W-1:0] X_RN_TAPS = 18'h08050;
  localparam logic [LFSR_W-1:0] Y_RN_TAPS = 18'h0FF60;

  typedef logic [0:0] state_t;
  localparam state_t ST_SEED = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  typedef enum logic [1:0] {
    ROT_0,
    ROT_90,
    ROT_180,
    ROT_270
  } rot_t;
endpackage

// File: rtl/gold_lfsr_pair.sv
// x/y LFSR pair with frame-start seed copy and 2-bit rotation index.
// Control priority: reload > restart > step > step_x_only.
module gold_lfsr_pair
  import gold_scrambler_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_step,
  input  logic       i_step_x_only,
  input  logic       i_reload,
  input  logic       i_restart,
  input  logic       i_latch_seed,
  output logic [1:0] o_rn
);
  logic [LFSR_W-1:0] r_x;
  logic [LFSR_W-1:0] r_y;
  logic [LFSR_W-1:0] r_x_seed;
  logic [LFSR_W-1:0] w_x_nxt;
  logic [LFSR_W-1:0] w_y_nxt;

  assign w_x_nxt = {^(r_x & X_FB_TAPS), r_x[LFSR_W-1:1]};
  assign w_y_nxt = {^(r_y & Y_FB_TAPS), r_y[LFSR_W-1:1]};

  assign o_rn[0] = r_x[0] ^ r_y[0];
  assign o_rn[1] = (^(r_x & X_RN_TAPS)) ^ (^(r_y & Y_RN_TAPS));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_x      <= X_RST;
      r_y      <= Y_RST;
      r_x_seed <= X_RST;
    end else begin
      if (i_latch_seed)
        r_x_seed <= r_x;
      if (i_reload) begin
        r_x <= X_RST;
        r_y <= Y_RST;
      end else if (i_restart) begin
        r_x <= r_x_seed;
        r_y <= Y_RST;
      end else if (i_step) begin
        r_x <= w_x_nxt;
        r_y <= w_y_nxt;
      end else if (i_step_x_only) begin
        r_x <= w_x_nxt;
      end
    end
  end
endmodule

// File: rtl/gold_scrambler.sv
// Gold-code I/Q scrambler: seeds x by code number, then rotates
// each symbol by a saturating quarter-turn chosen by Rn.
module gold_scrambler
  import gold_scrambler_pkg::*;
#(
  parameter int W         = 8,
  parameter int FRAME_LEN = 16,
  parameter int CODE_W    = 18
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [CODE_W-1:0] i_code,
  input  logic              i_code_load,
  input  logic              i_valid,
  input  logic [W-1:0]      i_i,
  input  logic [W-1:0]      i_q,
  output logic              o_in_ready,
  output logic              o_valid,
  output logic [W-1:0]      o_i,
  output logic [W-1:0]      o_q,
  output logic              o_last,
  input  logic              i_out_ready,
  output logic              o_seeding
);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] f_neg(input logic [W-1:0] a);
    f_neg = (a == MIN_VAL) ? ~a : -a;
  endfunction

  state_t            r_state;
  logic [CODE_W-1:0] r_remain;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic [W-1:0]      r_i;
  logic [W-1:0]      r_q;
  logic              r_last;

  logic       w_seeding;
  logic       w_in_ready;
  logic       w_xfer;
  logic       w_wrap;
  logic       w_remain_zero;
  logic [1:0] w_rn;
  rot_t       w_rot;
  logic [W-1:0] w_oi;
  logic [W-1:0] w_oq;

  assign w_seeding     = (r_state == ST_SEED);
  assign w_remain_zero = (r_remain == '0);
  // a code load steals the cycle from any pending transfer
  assign w_in_ready    = !w_seeding && !i_code_load
                       && (!r_valid || i_out_ready);
  assign w_xfer        = i_valid && w_in_ready;
  assign w_wrap        = w_xfer && (r_cnt == LAST_CNT);

  gold_lfsr_pair u_lfsr (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_step        (w_xfer && !w_wrap),
    .i_step_x_only (w_seeding && !i_code_load && !w_remain_zero),
    .i_reload      (i_code_load),
    .i_restart     (w_wrap),
    .i_latch_seed  (w_seeding && !i_code_load && w_remain_zero),
    .o_rn          (w_rn)
  );

  assign w_rot = rot_t'(w_rn);

  always_comb begin
    w_oi = i_i;
    w_oq = i_q;
    unique case (w_rot)
      ROT_0: begin
        w_oi = i_i;
        w_oq = i_q;
      end
      ROT_90: begin
        w_oi = f_neg(i_q);
        w_oq = i_i;
      end
      ROT_180: begin
        w_oi = f_neg(i_i);
        w_oq = f_neg(i_q);
      end
      ROT_270: begin
        w_oi = i_q;
        w_oq = f_neg(i_i);
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= ST_SEED;
      r_remain <= '0;
      r_cnt    <= '0;
    end else if (i_code_load) begin
      r_state  <= ST_SEED;
      r_remain <= i_code;
      r_cnt    <= '0;
    end else if (w_seeding) begin
      if (w_remain_zero)
        r_state <= ST_RUN;
      else
        r_remain <= r_remain - 1'b1;
    end else if (w_xfer) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_valid <= 1'b0;
      r_i     <= '0;
      r_q     <= '0;
      r_last  <= 1'b0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_i     <= w_oi;
      r_q     <= w_oq;
      r_last  <= (r_cnt == LAST_CNT);
    end else if (r_valid && i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_valid    = r_valid;
  assign o_i        = r_i;
  assign o_q        = r_q;
  assign o_last     = r_last;
  assign o_seeding  = w_seeding;
endmodule

// File: doc/gold_scrambler.md
GOLD_SCRAMBLER -- requirements
Module: gold_scrambler

Interface
REQ-001 Parameter W, default 8: signed I and Q sample width in bits.
REQ-002 Parameter FRAME_LEN, default 16, minimum 2: symbols per frame before the sequence restarts.
REQ-003 Parameter CODE_W, default 18: width of the scrambling code number.
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_reset_n  input  1  reset, synchronous and active-low.
REQ-006 i_code  input  CODE_W  scrambling code number n; sampled only when i_code_load=1.
REQ-007 i_code_load  input  1  one-cycle pulse that starts reseeding with i_code.
REQ-008 i_valid, i_i, i_q  input  1, W, W  input symbol (two's complement) and its valid flag.
REQ-009 o_in_ready  output  1  input accept flag.
REQ-010 o_valid, o_i, o_q, o_last  output  1, W, W, 1  scrambled symbol, valid flag and last-of-frame flag.
REQ-011 i_out_ready  input  1  downstream accept flag.
REQ-012 o_seeding  output  1  1 while the SEED state is active.

Function
REQ-013 Two 18-bit LFSRs, x and y; each step shifts right and inserts into bit 17: x17 = x7^x0 and y17 = y10^y7^y5^y0.
REQ-014 Rn[0] = x0^y0; Rn[1] = (x4^x6^x15)^(y5^y6^y8^y9^y10^y11^y12^y13^y14^y15); Rn is computed from the current, pre-step state.
REQ-015 Rotation by Rn: 0 gives (I,Q); 1 gives (-Q,I); 2 gives (-I,-Q); 3 gives (Q,-I).
REQ-016 Negation saturates: negating -2^(W-1) yields 2^(W-1)-1; all other results are exact at width W.
REQ-017 FSM states are SEED and RUN.
REQ-018 SEED, each cycle: if the remaining count is nonzero, step x only (y held at all-ones) and decrement the count; if it is zero, latch x_seed=x and go to RUN.
REQ-019 SEED therefore lasts n+1 cycles; o_in_ready=0 throughout.
REQ-020 RUN: o_in_ready = !o_valid || i_out_ready.
REQ-021 A transfer occurs when i_valid && o_in_ready in RUN.
REQ-022 On a transfer, in the same edge: the output register loads the rotated symbol; x and y step; the symbol counter increments.
REQ-023 Output latency is 1 cycle: o_valid is asserted the cycle after a transfer.
REQ-024 Frame wrap: on the transfer where counter==FRAME_LEN-1, o_last=1 is registered with that symbol, the counter becomes 0, x is loaded from x_seed and y from all-ones.
REQ-025 The symbol after a wrap uses the same Rn as symbol 0 of the previous frame.
REQ-026 o_valid stays high with o_i, o_q and o_last stable until i_out_ready=1; LFSR state does not change while no transfer occurs.
REQ-027 o_valid && i_out_ready with no new transfer clears o_valid; a simultaneous pop and transfer keeps o_valid=1 with the new data.
REQ-028 i_code_load at any time, including mid-frame and during SEED:
- x is set to 1 and y to all-ones;
- the counter is cleared;
- the remaining count is set to i_code;
- the state goes to SEED;
- any pending output register contents are kept and still delivered.
REQ-029 An i_code_load coinciding with a transfer takes priority: the transfer is not accepted, because o_in_ready is forced to 0 in that cycle.

Reset
REQ-030 When i_reset_n=0 at a clock edge:
- x=1, y=18'h3FFFF, x_seed=1;
- counter=0, remaining count=0, state=SEED;
- o_valid=0, o_last=0, o_i=0, o_q=0.
REQ-031 As a result, the first cycle after reset is SEED with code 0, and o_in_ready=0 and o_seeding=1 during that cycle.
REQ-032 Reset overrides i_code_load and any transfer in the same cycle.

Structure
REQ-033 Package gold_scrambler_pkg holds:
- LFSR width 18;
- x and y reset constants;
- tap positions for the feedback and for Rn[1];
- the FSM state typedef;
- the rotation enum.
REQ-034 Sub-module gold_lfsr_pair holds x, y and x_seed, has step, step_x_only, reload and restart controls, and outputs Rn.
REQ-035 Rotation, saturation, counter, FSM and handshake live in gold_scrambler.

Verification
REQ-036 Reset, 1 idle cycle, then input (5,-3) twice -> outputs (5,-3) with Rn=0, then (3,5) with Rn=1.
REQ-037 Rn=2 on input (-128,-128) with W=8 -> output (127,127); Rn=3 on (-128,7) -> (7,127).
REQ-038 FRAME_LEN=4, code 0, 8 back-to-back symbols -> o_last on symbols 3 and 7, and Rn sequence of symbols 4-7 equals that of symbols 0-3.
REQ-039 i_out_ready held 0 for 5 cycles with o_valid=1 -> output stable, o_in_ready=0, and the following Rn sequence is unchanged versus the no-stall run.
REQ-040 i_code_load with i_code=3 mid-frame -> o_seeding=1 and o_in_ready=0 for exactly 4 cycles; the next symbol's Rn matches the golden-model Rn of code 3, symbol 0; the counter restarts so o_last falls on the FRAME_LEN-th symbol after the load.
REQ-041 i_reset_n=0 asserted while o_valid=1 -> o_valid=0 on the next edge, and the post-reset output sequence is identical to scenario REQ-036.
